// File: rtl/eccop_alu_pkg.sv
// eccop_alu_pkg: shared function codes, opcode field layout and host select codes for the serial ALU
package eccop_alu_pkg;
  typedef enum logic [2:0] {
    F_LD  = 3'd0,
    F_ST  = 3'd1,
    F_ADD = 3'd2,
    F_SUB = 3'd3,
    F_ADC = 3'd4,
    F_SBB = 3'd5,
    F_SHR = 3'd6,
    F_SET = 3'd7
  } func_e;
  localparam int FIELD_W = 3;
  localparam int FUNC_LSB = 3;
  localparam int RSEL_LSB = 0;
  localparam int NREGS = 8;
  localparam logic [3:0] HOST_SEL_W = 4'd8;
endpackage

// File: rtl/eccop_alu_limb.sv
// eccop_alu_limb: combinational one-limb add/sub/shift/load datapath with carry in and out
module eccop_alu_limb
  import eccop_alu_pkg::*;
#(
  parameter int P_LIMB_W = 32
) (
  input  logic [P_LIMB_W-1:0] i_a,
  input  logic [P_LIMB_W-1:0] i_b,
  input  logic                i_cin,
  input  logic [2:0]          i_func,
  input  logic [2:0]          i_rsel,
  input  logic                i_lsb,
  output logic [P_LIMB_W-1:0] o_y,
  output logic                o_cout
);
  func_e w_f;
  logic w_add, w_sub;
  logic [P_LIMB_W:0] w_sum, w_dif;
  logic [P_LIMB_W-1:0] w_set;
  assign w_f = func_e'(i_func);
  assign w_add = (w_f == F_ADD) || (w_f == F_ADC);
  assign w_sub = (w_f == F_SUB) || (w_f == F_SBB);
  assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {{P_LIMB_W{1'b0}}, i_cin};
  assign w_dif = {1'b0, i_a} - {1'b0, i_b} - {{P_LIMB_W{1'b0}}, i_cin};
  assign w_set = (i_rsel == 3'd0) ? '0 : (i_rsel == 3'd1) ? {{(P_LIMB_W-1){1'b0}}, i_lsb} : '1;
  // Select the limb result; SHR takes the bit shifted out of the limb above as its new MSB
  always_comb begin
    o_y = w_add ? w_sum[P_LIMB_W-1:0] : w_sub ? w_dif[P_LIMB_W-1:0] :
          (w_f == F_SHR) ? {i_cin, i_a[P_LIMB_W-1:1]} : (w_f == F_LD) ? i_b :
          (w_f == F_SET) ? w_set : i_a;
    o_cout = w_add ? w_sum[P_LIMB_W] : w_sub ? w_dif[P_LIMB_W] : (w_f == F_SHR) ? i_a[0] : 1'b0;
  end
endmodule

// File: rtl/eccop_alu_serial.sv
// eccop_alu_serial: limb-serial multi-precision ALU with accumulator W, operand registers R0..R7 and host port
module eccop_alu_serial
  import eccop_alu_pkg::*;
#(
  parameter int P_LIMB_W = 32,
  parameter int P_LIMBS = 8,
  parameter int P_OPCODE_W = 6
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [P_OPCODE_W-1:0]      alu_op_code,
  input  logic                       alu_op_req,
  output logic                       alu_op_ack,
  output logic                       alu_flags_carry,
  output logic                       alu_flags_zero,
  output logic                       alu_flags_w0,
  input  logic [3:0]                 host_sel,
  input  logic [$clog2(P_LIMBS)-1:0] host_limb,
  input  logic                       host_we,
  input  logic                       host_re,
  input  logic [P_LIMB_W-1:0]        host_wdata,
  output logic [P_LIMB_W-1:0]        host_rdata,
  output logic                       host_busy
);
  localparam int LW = $clog2(P_LIMBS);
  localparam logic [LW-1:0] LAST = LW'(P_LIMBS - 1);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ACK} state_e;
  state_e r_state;
  func_e r_func;
  logic [2:0] r_rsel;
  logic [LW-1:0] r_idx, r_cnt;
  logic r_cy, r_nz, r_w0;
  logic [P_LIMB_W-1:0] r_w [P_LIMBS];
  logic [P_LIMB_W-1:0] r_r [NREGS][P_LIMBS];
  func_e w_func;
  logic [P_LIMB_W-1:0] w_y;
  logic w_cout, w_nz;
  assign w_func = func_e'(alu_op_code[FUNC_LSB +: FIELD_W]);
  assign w_nz = r_nz | (|w_y);
  eccop_alu_limb #(.P_LIMB_W(P_LIMB_W)) u_limb (
    .i_a(r_w[r_idx]),
    .i_b(r_r[r_rsel][r_idx]),
    .i_cin(r_cy),
    .i_func(r_func),
    .i_rsel(r_rsel),
    .i_lsb(r_idx == '0),
    .o_y(w_y),
    .o_cout(w_cout)
  );
  // Control FSM, one limb per RUN cycle, flag update at ACK entry, and host register access while idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_func <= F_LD;
      r_rsel <= '0;
      r_idx <= '0;
      r_cnt <= '0;
      r_cy <= 1'b0;
      r_nz <= 1'b0;
      r_w0 <= 1'b0;
      alu_op_ack <= 1'b0;
      alu_flags_carry <= 1'b0;
      alu_flags_zero <= 1'b0;
      alu_flags_w0 <= 1'b0;
      host_rdata <= '0;
      host_busy <= 1'b0;
      for (int i = 0; i < P_LIMBS; i++) r_w[i] <= '0;
      for (int i = 0; i < NREGS; i++) for (int j = 0; j < P_LIMBS; j++) r_r[i][j] <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (alu_op_req) begin
          r_func <= w_func;
          r_rsel <= alu_op_code[RSEL_LSB +: FIELD_W];
          r_idx <= (w_func == F_SHR) ? LAST : '0;
          r_cnt <= '0;
          r_cy <= (w_func == F_ADC || w_func == F_SBB) ? alu_flags_carry : 1'b0;
          r_nz <= 1'b0;
          host_busy <= 1'b1;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (r_func == F_ST) r_r[r_rsel][r_idx] <= r_w[r_idx];
          else r_w[r_idx] <= w_y;
          if (r_idx == '0) r_w0 <= w_y[0];
          r_cy <= w_cout;
          r_nz <= w_nz;
          r_idx <= (r_func == F_SHR) ? r_idx - 1'b1 : r_idx + 1'b1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            alu_op_ack <= 1'b1;
            alu_flags_carry <= w_cout;
            alu_flags_zero <= ~w_nz;
            alu_flags_w0 <= (r_idx == '0) ? w_y[0] : r_w0;
            r_state <= S_ACK;
          end
        end
        default: begin
          alu_op_ack <= 1'b0;
          host_busy <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
      if (!host_busy) begin
        if (host_we && host_sel == HOST_SEL_W) r_w[host_limb] <= host_wdata;
        else if (host_we && !host_sel[3]) r_r[host_sel[2:0]][host_limb] <= host_wdata;
        if (host_re) host_rdata <= (host_sel == HOST_SEL_W) ? r_w[host_limb] :
                                   !host_sel[3] ? r_r[host_sel[2:0]][host_limb] : '0;
      end
    end
  end
endmodule

// File: tb/tb_eccop_alu_serial.sv
// tb_eccop_alu_serial: scoreboard bench for the limb-serial ALU against a 256-bit reference model
module tb_eccop_alu_serial;
  localparam int LW = 32;
  localparam int NL = 8;
  localparam int N = LW * NL;
  typedef struct packed {logic [N-1:0] w; logic c; logic z; logic w0;} exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [5:0] alu_op_code = '0;
  logic alu_op_req = 1'b0;
  logic alu_op_ack, alu_flags_carry, alu_flags_zero, alu_flags_w0;
  logic [3:0] host_sel = '0;
  logic [2:0] host_limb = '0;
  logic host_we = 1'b0;
  logic host_re = 1'b0;
  logic [LW-1:0] host_wdata = '0;
  logic [LW-1:0] host_rdata;
  logic host_busy;
  exp_t sb[$];
  logic [N-1:0] m_w;
  logic [N-1:0] m_r [8];
  logic m_c;
  int n_chk = 0;
  int n_fail = 0;
  int ack_cnt = 0;
  eccop_alu_serial #(.P_LIMB_W(LW), .P_LIMBS(NL), .P_OPCODE_W(6)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .alu_op_code(alu_op_code),
    .alu_op_req(alu_op_req),
    .alu_op_ack(alu_op_ack),
    .alu_flags_carry(alu_flags_carry),
    .alu_flags_zero(alu_flags_zero),
    .alu_flags_w0(alu_flags_w0),
    .host_sel(host_sel),
    .host_limb(host_limb),
    .host_we(host_we),
    .host_re(host_re),
    .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .host_busy(host_busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (alu_op_ack === 1'b1) ack_cnt++;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
  task automatic model_clear();
    m_w = '0;
    m_c = 1'b0;
    for (int i = 0; i < 8; i++) m_r[i] = '0;
  endtask
  task automatic model(input logic [5:0] op);
    logic [2:0] f, r;
    logic [N:0] t;
    exp_t e;
    f = op[5:3];
    r = op[2:0];
    t = '0;
    case (f)
      3'd0: begin m_w = m_r[r]; m_c = 1'b0; end
      3'd1: begin m_r[r] = m_w; m_c = 1'b0; end
      3'd2: begin t = {1'b0, m_w} + {1'b0, m_r[r]}; m_w = t[N-1:0]; m_c = t[N]; end
      3'd3: begin t = {1'b0, m_w} - {1'b0, m_r[r]}; m_w = t[N-1:0]; m_c = t[N]; end
      3'd4: begin t = {1'b0, m_w} + {1'b0, m_r[r]} + {{N{1'b0}}, m_c}; m_w = t[N-1:0]; m_c = t[N]; end
      3'd5: begin t = {1'b0, m_w} - {1'b0, m_r[r]} - {{N{1'b0}}, m_c}; m_w = t[N-1:0]; m_c = t[N]; end
      3'd6: begin m_c = m_w[0]; m_w = m_w >> 1; end
      default: begin m_w = (r == 3'd0) ? '0 : (r == 3'd1) ? N'(1) : '1; m_c = 1'b0; end
    endcase
    e.w = m_w;
    e.c = m_c;
    e.z = (m_w == '0);
    e.w0 = m_w[0];
    sb.push_back(e);
  endtask
  task automatic write_reg(input logic [3:0] sel, input logic [N-1:0] v);
    for (int l = 0; l < NL; l++) begin
      @(negedge clk);
      host_sel = sel; host_limb = 3'(l); host_wdata = v[l*LW +: LW]; host_we = 1'b1;
    end
    @(negedge clk);
    host_we = 1'b0;
    if (sel == 4'd8) m_w = v; else m_r[sel[2:0]] = v;
  endtask
  task automatic read_reg(input logic [3:0] sel, output logic [N-1:0] v);
    v = '0;
    for (int l = 0; l < NL; l++) begin
      @(negedge clk);
      host_sel = sel; host_limb = 3'(l); host_re = 1'b1;
      @(negedge clk);
      host_re = 1'b0;
      v[l*LW +: LW] = host_rdata;
    end
  endtask
  task automatic do_op(input logic [5:0] op, input int poke, output int lat);
    model(op);
    @(negedge clk);
    alu_op_code = op;
    alu_op_req = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == poke) begin
        host_sel = 4'd5; host_limb = 3'd2; host_wdata = 32'hDEAD_BEEF; host_we = 1'b1;
      end else host_we = 1'b0;
      if (alu_op_ack === 1'b1) begin lat = k; break; end
    end
    alu_op_req = 1'b0;
    host_we = 1'b0;
  endtask
  task automatic test_reset();
    logic [N-1:0] v;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({alu_op_ack, alu_flags_carry, alu_flags_zero, alu_flags_w0, host_busy, host_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ack=%b c=%b z=%b w0=%b busy=%b rdata=%h required all 0",
               alu_op_ack, alu_flags_carry, alu_flags_zero, alu_flags_w0, host_busy, host_rdata);
    end
    reset_n = 1'b1;
    model_clear();
    read_reg(4'd8, v);
    n_chk++;
    if (v !== '0) begin n_fail++; $display("FAIL reset_w: got %h required 0", v); end
  endtask
  task automatic test_reset_mid_run();
    logic [N-1:0] v;
    int a0;
    write_reg(4'd0, {8{32'h1234_5678}});
    @(negedge clk);
    alu_op_code = {3'd2, 3'd0};
    alu_op_req = 1'b1;
    repeat (4) @(negedge clk);
    n_chk++;
    if (host_busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_run: got %b required 1", host_busy); end
    a0 = ack_cnt;
    reset_n = 1'b0;
    alu_op_req = 1'b0;
    @(negedge clk);
    n_chk++;
    if (host_busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_reset: got %b required 0", host_busy); end
    reset_n = 1'b1;
    model_clear();
    repeat (12) @(negedge clk);
    n_chk++;
    if (ack_cnt !== a0) begin n_fail++; $display("FAIL mid_run_ack: got %0d acks required %0d", ack_cnt, a0); end
    read_reg(4'd0, v);
    n_chk++;
    if (v !== '0) begin n_fail++; $display("FAIL mid_run_r0: got %h required 0", v); end
    read_reg(4'd8, v);
    n_chk++;
    if (v !== '0) begin n_fail++; $display("FAIL mid_run_w: got %h required 0", v); end
  endtask
  task automatic run_table(input string name, input logic [5:0] ops[4], input int cnt, input int poke);
    exp_t e;
    int lat;
    for (int i = 0; i < cnt; i++) begin
      do_op(ops[i], poke, lat);
      e = sb.pop_front();
      n_chk++;
      if (lat !== 9) begin n_fail++; $display("FAIL %s_latency[%0d]: got %0d required 9", name, i, lat); end
      n_chk++;
      if ({alu_flags_carry, alu_flags_zero, alu_flags_w0} !== {e.c, e.z, e.w0}) begin
        n_fail++;
        $display("FAIL %s_flags[%0d]: got c/z/w0=%b%b%b required %b%b%b", name, i,
                 alu_flags_carry, alu_flags_zero, alu_flags_w0, e.c, e.z, e.w0);
      end
    end
  endtask
  task automatic test_add();
    logic [N-1:0] v;
    logic [5:0] ops[4];
    write_reg(4'd0, '1);
    write_reg(4'd1, N'(1));
    ops = '{{3'd0, 3'd0}, {3'd2, 3'd1}, 6'd0, 6'd0};
    run_table("add", ops, 2, 0);
    n_chk++;
    if ({alu_flags_carry, alu_flags_zero, alu_flags_w0} !== 3'b110) begin
      n_fail++; $display("FAIL add_wrap_flags: got %b%b%b required 110", alu_flags_carry, alu_flags_zero, alu_flags_w0);
    end
    read_reg(4'd8, v);
    n_chk++;
    if (v !== '0) begin n_fail++; $display("FAIL add_w: got %h required 0", v); end
  endtask
  task automatic test_sub();
    logic [N-1:0] v;
    logic [5:0] ops[4];
    write_reg(4'd8, N'(5));
    write_reg(4'd2, N'(7));
    write_reg(4'd3, '0);
    ops = '{{3'd3, 3'd2}, {3'd5, 3'd3}, 6'd0, 6'd0};
    run_table("sub", ops, 2, 0);
    read_reg(4'd8, v);
    n_chk++;
    if (v !== ~N'(2)) begin n_fail++; $display("FAIL sbb_w: got %h required %h", v, ~N'(2)); end
    n_chk++;
    if (v !== m_w) begin n_fail++; $display("FAIL sub_model_w: got %h required %h", v, m_w); end
  endtask
  task automatic test_shr();
    logic [N-1:0] v;
    logic [5:0] ops[4];
    ops = '{{3'd7, 3'd1}, {3'd6, 3'd0}, {3'd7, 3'd2}, {3'd6, 3'd5}};
    run_table("shr", ops, 4, 0);
    read_reg(4'd8, v);
    n_chk++;
    if (v !== {32'h7FFF_FFFF, {7{32'hFFFF_FFFF}}}) begin
      n_fail++; $display("FAIL shr_w: got %h required 7fffffff then all-ones", v);
    end
  endtask
  task automatic test_st_host();
    logic [N-1:0] v;
    logic [5:0] ops[4];
    ops = '{{3'd1, 3'd4}, 6'd0, 6'd0, 6'd0};
    run_table("st", ops, 1, 3);
    read_reg(4'd4, v);
    n_chk++;
    if (v !== m_w) begin n_fail++; $display("FAIL st_r4: got %h required %h", v, m_w); end
    read_reg(4'd5, v);
    n_chk++;
    if (v !== m_r[5]) begin n_fail++; $display("FAIL busy_write_dropped: got %h required %h", v, m_r[5]); end
    @(negedge clk);
    host_sel = 4'd6; host_limb = 3'd1; host_wdata = 32'hAAAA_5555; host_we = 1'b1;
    @(negedge clk);
    host_wdata = 32'h1357_9BDF; host_re = 1'b1;
    @(negedge clk);
    host_we = 1'b0; host_re = 1'b0;
    n_chk++;
    if (host_rdata !== 32'hAAAA_5555) begin n_fail++; $display("FAIL we_re_old: got %h required aaaa5555", host_rdata); end
    m_r[6][63:32] = 32'h1357_9BDF;
    read_reg(4'd6, v);
    n_chk++;
    if (v !== m_r[6]) begin n_fail++; $display("FAIL we_re_new: got %h required %h", v, m_r[6]); end
  endtask
  task automatic test_random();
    logic [N-1:0] v;
    exp_t e;
    int lat, a0;
    for (int s = 0; s < 9; s++) begin
      for (int l = 0; l < NL; l++) v[l*LW +: LW] = $urandom;
      write_reg(4'(s), v);
    end
    a0 = ack_cnt;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(6'($urandom_range(0, 63)), 0, lat);
      e = sb.pop_front();
      n_chk++;
      if (lat !== 9) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d required 9", i, lat); end
      n_chk++;
      if ({alu_flags_carry, alu_flags_zero, alu_flags_w0} !== {e.c, e.z, e.w0}) begin
        n_fail++;
        $display("FAIL rand_flags[%0d] op=%h: got %b%b%b required %b%b%b", i, alu_op_code,
                 alu_flags_carry, alu_flags_zero, alu_flags_w0, e.c, e.z, e.w0);
      end
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (ack_cnt - a0 !== 30) begin n_fail++; $display("FAIL rand_ack_count: got %0d required 30", ack_cnt - a0); end
    read_reg(4'd8, v);
    n_chk++;
    if (v !== m_w) begin n_fail++; $display("FAIL rand_w: got %h required %h", v, m_w); end
  endtask
  initial begin
    test_reset();
    test_reset_mid_run();
    test_add();
    test_sub();
    test_shr();
    test_st_host();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
